// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the multi-cycle ALU slice.
//   op_e    : operation select encodings carried on sel[2:0]
//   state_e : control FSM states of alu_mc
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_NOT = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if -- request/response bundle of the multi-cycle ALU.
//   request : in_valid/in_ready handshake carrying opA, opB, sel
//   response: out_valid/out_ready handshake carrying res and flags z/c/v
//   master  : requester/consumer side, slave : the ALU
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [2:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             z;
  logic             c;
  logic             v;

  modport master (
    output in_valid, opA, opB, sel, out_ready,
    input  in_ready, out_valid, res, z, c, v
  );

  modport slave (
    input  in_valid, opA, opB, sel, out_ready,
    output in_ready, out_valid, res, z, c, v
  );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq -- iterative unsigned shift-add multiplier, one partial
// product per cycle.
//   clk, rst : clock, synchronous active-high reset (clears all state)
//   start    : load a/b and begin; must only pulse while idle
//   a, b     : multiplicand, multiplier (sampled on start)
//   done     : high during the final step; prod is the full product then
//   prod     : accumulator value after the current step (2*WIDTH bits)
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);
  localparam int CW = $clog2(WIDTH);

  logic               busy;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  // prod is the post-step value so the consumer can capture the final
  // product on the same edge that retires the last step.
  assign prod = acc + (mplier[0] ? mcand : '0);
  assign done = busy && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (busy) begin
      acc    <= prod;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc -- multi-cycle ALU with valid/ready handshakes on both sides.
//   clk, rst : clock, synchronous active-high reset (aborts any operation)
//   bus      : alu_mc_if slave port (request opA/opB/sel, response res/z/c/v)
// Single-cycle ops are computed combinationally and registered on the
// accept edge; OP_MUL runs the iterative multiplier for WIDTH cycles.
// Results are held in DONE until out_ready; only IDLE accepts requests.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst,
  alu_mc_if.slave  bus
);

  state_e           state;
  logic             rdy_q;
  logic             ov_q;
  logic [WIDTH-1:0] res_q;
  logic             z_q, c_q, v_q;

  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [WIDTH:0]   sum_x, shl_x, shr_x;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   n;

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = ov_q;
  assign bus.res       = res_q;
  assign bus.z         = z_q;
  assign bus.c         = c_q;
  assign bus.v         = v_q;

  assign accept    = bus.in_valid && rdy_q;
  assign mul_start = accept && (op_e'(bus.sel) == OP_MUL);

  assign n     = bus.opB[SHW-1:0];
  assign sum_x = {1'b0, bus.opA} + {1'b0, bus.opB};
  assign diff  = bus.opA - bus.opB;
  // Bit WIDTH of the left-extended shift, and bit 0 of the right-extended
  // shift, hold the last bit shifted out (0 when n==0).
  assign shl_x = {1'b0, bus.opA} << n;
  assign shr_x = {bus.opA, 1'b0} >> n;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_e'(bus.sel))
      OP_ADD: begin
        alu_res = sum_x[WIDTH-1:0];
        alu_c   = sum_x[WIDTH];
        alu_v   = (bus.opA[WIDTH-1] == bus.opB[WIDTH-1]) &&
                  (sum_x[WIDTH-1] != bus.opA[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_c   = bus.opA < bus.opB;
        alu_v   = (bus.opA[WIDTH-1] != bus.opB[WIDTH-1]) &&
                  (diff[WIDTH-1] != bus.opA[WIDTH-1]);
      end
      OP_AND: alu_res = bus.opA & bus.opB;
      OP_OR:  alu_res = bus.opA | bus.opB;
      OP_NOT: alu_res = ~bus.opA;
      OP_SHL: begin
        alu_res = shl_x[WIDTH-1:0];
        alu_c   = shl_x[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_x[WIDTH:1];
        alu_c   = shr_x[0];
      end
      default: ;
    endcase
  end

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (bus.opA),
    .b     (bus.opB),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rdy_q <= 1'b1;
      ov_q  <= 1'b0;
      res_q <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          rdy_q <= 1'b0;
          if (op_e'(bus.sel) == OP_MUL) begin
            state <= BUSY;
          end else begin
            state <= DONE;
            ov_q  <= 1'b1;
            res_q <= alu_res;
            z_q   <= (alu_res == '0);
            c_q   <= alu_c;
            v_q   <= alu_v;
          end
        end
        BUSY: if (mul_done) begin
          state <= DONE;
          ov_q  <= 1'b1;
          res_q <= mul_prod[WIDTH-1:0];
          z_q   <= (mul_prod[WIDTH-1:0] == '0);
          c_q   <= |mul_prod[2*WIDTH-1:WIDTH];
          v_q   <= 1'b0;
        end
        DONE: if (bus.out_ready) begin
          // in_ready rises only after this edge, so no same-cycle accept.
          state <= IDLE;
          ov_q  <= 1'b0;
          rdy_q <= 1'b1;
        end
        default: begin
          state <= IDLE;
          rdy_q <= 1'b1;
          ov_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic         z, c, v;
    int           lat;
    int           acc_cyc;
    string        name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t cur;
  bit   seen = 1'b0;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard when a new result appears, then checks
  // that a held result stays stable while backpressured.
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else if (bus.out_valid) begin
      chk("in_ready_low_in_done", bus.in_ready, 0);
      if (!seen) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got res %0h, expected none", bus.res);
        end else begin
          cur = q.pop_front();
          chk({cur.name, "_lat"}, cyc - cur.acc_cyc, cur.lat);
          chk({cur.name, "_res"}, bus.res, cur.res);
          chk({cur.name, "_z"}, bus.z, cur.z);
          chk({cur.name, "_c"}, bus.c, cur.c);
          chk({cur.name, "_v"}, bus.v, cur.v);
        end
        seen = 1'b1;
      end else begin
        chk("held_res", bus.res, cur.res);
        chk("held_flags", {bus.z, bus.c, bus.v}, {cur.z, cur.c, cur.v});
      end
      if (bus.out_ready) seen = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present one request once in_ready is seen, push its expectation, and
  // scramble the operand bus right after the accept edge.
  task automatic issue(input string name, input logic [2:0] sel,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] r, input logic z, input logic c,
                       input logic v);
    exp_t e;
    int t = 0;
    while (!bus.in_ready && t < 200) begin tick(); t++; end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL %s_wait_ready: in_ready 0, expected 1", name);
    end
    e.res = r; e.z = z; e.c = c; e.v = v; e.name = name;
    e.lat = (sel == OP_MUL) ? W + 1 : 1;
    e.acc_cyc = cyc;
    q.push_back(e);
    bus.in_valid = 1'b1; bus.sel = sel; bus.opA = a; bus.opB = b;
    tick();
    bus.in_valid = 1'b0; bus.opA = ~a; bus.opB = b ^ 32'h5A5A_A5A5;
    bus.sel = ~sel;
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || bus.out_valid) && t < 200) begin tick(); t++; end
    if (q.size() != 0 || bus.out_valid) begin
      checks++; errors++;
      $display("FAIL drain_timeout: pending %0d, expected 0", q.size());
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.opA = '0; bus.opB = '0; bus.sel = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    tick(); tick();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_res", bus.res, 0);
    chk("rst_flags", {bus.z, bus.c, bus.v}, 0);
    rst = 1'b0;
    tick();

    issue("add_ovf",  OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 0, 1);
    issue("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1, 0);
    issue("sub_eq",   OP_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1, 0, 0);
    issue("sub_brw",  OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 0, 1, 0);
    issue("sub_ovf",  OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 0, 0, 1);
    issue("and",      OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 0);
    issue("or",       OP_OR,  32'h0F0F_0000, 32'h0000_00FF, 32'h0F0F_00FF, 0, 0, 0);
    issue("not",      OP_NOT, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 1, 0, 0);
    issue("shl1",     OP_SHL, 32'h8000_0001, 32'h0000_0001, 32'h0000_0002, 0, 1, 0);
    issue("shr0",     OP_SHR, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 0, 0, 0);
    issue("shr1",     OP_SHR, 32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 0, 1, 0);
    issue("shl31",    OP_SHL, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 0);
    issue("shr31",    OP_SHR, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 0, 0, 0);
    issue("mul_hi",   OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1, 1, 0);
    issue("mul_3x7",  OP_MUL, 32'h0000_0003, 32'h0000_0007, 32'h0000_0015, 0, 0, 0);
    issue("mul_max",  OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1, 0);
    drain();

    // Backpressure: hold the add result 5 cycles while pushing a stray request.
    bus.out_ready = 1'b0;
    issue("bp_add", OP_ADD, 32'h0000_0002, 32'h0000_0002, 32'h0000_0004, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.sel = OP_OR; bus.opA = 32'hDEAD_BEEF;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // Reset in the middle of a multiply aborts it with no result.
    issue("mul_abort", OP_MUL, 32'h0000_0009, 32'h0000_0009, 32'h0000_0051, 0, 0, 0);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(q.pop_back());
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_res", bus.res, 0);
    chk("abort_flags", {bus.z, bus.c, bus.v}, 0);
    repeat (W + 4) begin
      tick();
      chk("abort_no_result", bus.out_valid, 0);
    end
    issue("post_add", OP_ADD, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 0, 0, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (legal range 4..64, power of two).
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), meaning shift-amount width taken from opB[SHW-1:0].
REQ-003 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid  input  1  request present on opA/opB/sel.
REQ-006 The block SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-007 The block SHALL have port opA  input  WIDTH  first operand.
REQ-008 The block SHALL have port opB  input  WIDTH  second operand or shift amount.
REQ-009 The block SHALL have port sel  input  3  operation select.
REQ-010 The block SHALL have port out_valid  output  1  res/z/c/v hold a completed result.
REQ-011 The block SHALL have port out_ready  input  1  consumer accepts the result this cycle.
REQ-012 The block SHALL have port res  output  WIDTH  registered result.
REQ-013 The block SHALL have ports z, c, v  output  1 each  registered zero, carry, overflow flags.

Function
REQ-014 The block SHALL accept a request on a rising edge where in_valid and in_ready are both 1, capturing opA, opB, sel.
REQ-015 The block SHALL implement states IDLE (in_ready=1), BUSY (multiply in progress), DONE (out_valid=1); in_ready SHALL be 1 only in IDLE.
REQ-016 Transitions: IDLE->DONE on accept of sel!=111; IDLE->BUSY on accept of sel=111; BUSY->DONE after WIDTH iterations; DONE->IDLE when out_ready=1.
REQ-017 Latency: out_valid SHALL assert on the cycle after accept for sel 000..110, and WIDTH+1 cycles after accept for sel 111.
REQ-018 In DONE, res/z/c/v SHALL be held stable until the out_ready handshake; a new request SHALL NOT be accepted in the same cycle as DONE->IDLE.
REQ-019 sel=000 add: {c,res}=opA+opB in WIDTH+1 bits; v=1 when opA,opB signs equal and res sign differs.
REQ-020 sel=001 sub: res=opA-opB; c=1 iff opA<opB unsigned (borrow); v=1 when opA,opB signs differ and res sign differs from opA.
REQ-021 sel=010 AND, 011 OR, 100 NOT opA: c=0, v=0.
REQ-022 sel=101 logical shift left by n=opB[SHW-1:0], sel=110 logical shift right by n: c=last bit shifted out (c=0 when n=0), v=0.
REQ-023 sel=111 unsigned multiply, iterative shift-add, one partial step per cycle: res=low WIDTH bits of product, c=1 iff high WIDTH bits nonzero, v=0.
REQ-024 z SHALL be 1 iff res equals zero, for every operation.
REQ-025 All arithmetic wraps modulo 2^WIDTH; no saturation.
REQ-026 Changes to opA/opB/sel after accept SHALL NOT affect the in-flight result.
REQ-027 The block SHALL contain no simulation print statements.

Reset
REQ-028 With rst=1 at a rising edge: state=IDLE, in_ready=1, out_valid=0, res=0, z=0, c=0, v=0, multiplier registers cleared.
REQ-029 rst during BUSY or DONE SHALL abort the operation with no result delivered; rst has priority over in_valid.

Structure
REQ-030 Package alu_pkg SHALL hold the sel encodings (OP_ADD..OP_MUL) and the state enumeration (IDLE, BUSY, DONE).
REQ-031 The iterative multiplier SHALL be a sub-module alu_mul_seq (start, done, WIDTH parameter), instantiated once.
REQ-032 Single-cycle operations SHALL be combinational into the result register; no other sub-modules.

Verification
REQ-033 WIDTH=32, add 0x7FFFFFFF+0x00000001 -> next cycle out_valid=1, res=0x80000000, z=0, c=0, v=1.
REQ-034 sub 0x00000005-0x00000005 -> res=0, z=1, c=0, v=0; sub 0x00000000-0x00000001 -> res=0xFFFFFFFF, c=1, v=0.
REQ-035 shl 0x80000001 by 1 -> res=0x00000002, c=1; shr 0x00000001 by 0 -> res=0x00000001, c=0.
REQ-036 mul 0x00010000*0x00010000 -> out_valid exactly 33 cycles after accept, res=0, z=1, c=1; mul 3*7 -> res=21, c=0.
REQ-037 Backpressure: hold out_ready=0 for 5 cycles after an add result -> res/flags stable, in_ready=0 throughout, in_valid ignored.
REQ-038 Assert rst at cycle 10 of a multiply -> next cycle IDLE, out_valid=0, all outputs 0; following add 2+3 -> res=5.
